// File: rtl/branch_resolve_pkg.sv
// Shared constants and the ID/EX branch record for the EX-stage branch resolution unit.
//   BRANCH_WIDTH   : width of the branch type field (class [4:3], condition [2:0])
//   BRANCH_*       : branch class codes
//   BCOND_*        : condition codes for class B
//   br_rec_t       : record captured from ID into the ID/EX branch register
package branch_resolve_pkg;

  localparam int unsigned BRANCH_WIDTH = 5;
  localparam int unsigned PC_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH   = 32;

  localparam logic [1:0] BRANCH_NONE = 2'b00;
  localparam logic [1:0] BRANCH_B    = 2'b01;
  localparam logic [1:0] BRANCH_J    = 2'b10;

  localparam logic [2:0] BCOND_BEQ  = 3'b000;
  localparam logic [2:0] BCOND_BNE  = 3'b001;
  localparam logic [2:0] BCOND_BLEZ = 3'b010;
  localparam logic [2:0] BCOND_BGTZ = 3'b011;
  localparam logic [2:0] BCOND_BLTZ = 3'b100;
  localparam logic [2:0] BCOND_BGEZ = 3'b101;

  typedef struct packed {
    logic [BRANCH_WIDTH-1:0] btype;
    logic [PC_WIDTH-1:0]     dst;
    logic [PC_WIDTH-1:0]     pc_plus4;
    logic                    pred_taken;
  } br_rec_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Bus bundle between the pipeline and branch_resolve.
//   slave  : the resolution unit (takes ID record, operands, stall/flush; drives EX results, counters)
//   master : the surrounding pipeline / testbench
interface branch_resolve_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  import branch_resolve_pkg::*;

  logic                          stall;
  logic                          flush_in;
  logic [BRANCH_WIDTH-1:0]       id_branchType;
  logic [PC_WIDTH-1:0]           id_branchDst;
  logic [PC_WIDTH-1:0]           id_pcPlus4;
  logic                          id_predTaken;
  logic [DATA_WIDTH-1:0]         rs_val;
  logic [DATA_WIDTH-1:0]         rt_val;
  logic [BRANCH_WIDTH-1:0]       ex_branchType;
  logic                          ex_branchPermit;
  logic                          ex_mispredict;
  logic [PC_WIDTH-1:0]           ex_redirectPc;
  logic [CNT_WIDTH-1:0]          branchCount;
  logic [CNT_WIDTH-1:0]          mispredictCount;

  modport master (
    output stall, flush_in, id_branchType, id_branchDst, id_pcPlus4, id_predTaken,
           rs_val, rt_val,
    input  ex_branchType, ex_branchPermit, ex_mispredict, ex_redirectPc,
           branchCount, mispredictCount
  );

  modport slave (
    input  stall, flush_in, id_branchType, id_branchDst, id_pcPlus4, id_predTaken,
           rs_val, rt_val,
    output ex_branchType, ex_branchPermit, ex_mispredict, ex_redirectPc,
           branchCount, mispredictCount
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator (signed 32-bit compares).
//   cond_i  : condition code
//   rs_i    : first operand
//   rt_i    : second operand (BEQ/BNE only)
//   taken_o : combinational condition result; reserved codes give not-taken
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0]            cond_i,
  input  logic [DATA_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0] rt_i,
  output logic                  taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      BCOND_BEQ:  taken_o = (rs_i == rt_i);
      BCOND_BNE:  taken_o = (rs_i != rt_i);
      BCOND_BLEZ: taken_o = ($signed(rs_i) <= 32'sd0);
      BCOND_BGTZ: taken_o = ($signed(rs_i) >  32'sd0);
      BCOND_BLTZ: taken_o = ($signed(rs_i) <  32'sd0);
      BCOND_BGEZ: taken_o = ($signed(rs_i) >= 32'sd0);
      default:    taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: ID/EX branch register, condition evaluation,
// mispredict redirect with wrong-path kill, saturating performance counters.
//   clk, rst : clock, synchronous active-low reset
//   br       : branch_resolve_if slave (ID record, operands, stall/flush in;
//              EX type/permit/mispredict/redirect and counters out)
// ex_branchPermit, ex_mispredict and ex_redirectPc are combinational from the
// register and the current forwarded operands.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  branch_resolve_if.slave br
);

  br_rec_t              rec_q, rec_d;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  logic is_b;
  logic cond_taken;
  logic permit;
  logic resolve;
  logic mispredict;

  branch_cond u_cond (
    .cond_i  (rec_q.btype[2:0]),
    .rs_i    (br.rs_val),
    .rt_i    (br.rt_val),
    .taken_o (cond_taken)
  );

  // Resolution is deferred while stalled so each branch is counted once.
  assign is_b       = (rec_q.btype[4:3] == BRANCH_B);
  assign permit     = is_b & cond_taken;
  assign resolve    = is_b & ~br.stall;
  assign mispredict = resolve & (permit != rec_q.pred_taken);

  // Next record: stall holds; flush or own mispredict kills the ID instruction.
  always_comb begin
    rec_d = rec_q;
    if (!br.stall) begin
      if (br.flush_in || mispredict) begin
        rec_d = '0;
        rec_d.btype = {BRANCH_NONE, 3'b000};
      end else begin
        rec_d.btype      = br.id_branchType;
        rec_d.dst        = br.id_branchDst;
        rec_d.pc_plus4   = br.id_pcPlus4;
        rec_d.pred_taken = br.id_predTaken;
      end
    end
  end

  // Saturating counters.
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (resolve && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_WIDTH'(1);
    if (mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rec_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      rec_q  <= rec_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign br.ex_branchType   = rec_q.btype;
  assign br.ex_branchPermit = permit;
  assign br.ex_mispredict   = mispredict;
  assign br.ex_redirectPc   = mispredict ? (permit ? rec_q.dst : rec_q.pc_plus4) : '0;
  assign br.branchCount     = bcnt_q;
  assign br.mispredictCount = mcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve: table of single-branch vectors plus
// hand-written stall, back-to-back, saturation and reset sequences.
// A second instance with 4-bit counters shares all stimulus to exercise saturation.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.CNT_WIDTH(16)) bif ();
  branch_resolve_if #(.CNT_WIDTH(4))  sif ();

  branch_resolve #(.CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bif.slave)
  );

  branch_resolve #(.CNT_WIDTH(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .br  (sif.slave)
  );

  assign sif.stall         = bif.stall;
  assign sif.flush_in      = bif.flush_in;
  assign sif.id_branchType = bif.id_branchType;
  assign sif.id_branchDst  = bif.id_branchDst;
  assign sif.id_pcPlus4    = bif.id_pcPlus4;
  assign sif.id_predTaken  = bif.id_predTaken;
  assign sif.rs_val        = bif.rs_val;
  assign sif.rt_val        = bif.rt_val;

  typedef struct {
    logic [4:0]  btype;
    logic [31:0] dst;
    logic [31:0] pc4;
    logic        pred;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_permit;
    logic        exp_misp;
    logic [31:0] exp_redir;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int raw_bc = 0;
  int raw_mc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, " bcnt"},     32'(bif.branchCount),     32'(raw_bc));
    chk({tag, " mcnt"},     32'(bif.mispredictCount), 32'(raw_mc));
    chk({tag, " sat_bcnt"}, 32'(sif.branchCount),     32'(sat(raw_bc, 15)));
    chk({tag, " sat_mcnt"}, 32'(sif.mispredictCount), 32'(sat(raw_mc, 15)));
  endtask

  task automatic set_id(input logic [4:0] t, input logic [31:0] d, input logic [31:0] p,
                        input logic pr);
    bif.id_branchType = t;
    bif.id_branchDst  = d;
    bif.id_pcPlus4    = p;
    bif.id_predTaken  = pr;
  endtask

  vec_t vecs[12];

  initial begin
    //             type      dst         pc4         pred rs            rt        perm misp redir
    vecs[0]  = '{5'b01000, 32'h100, 32'h44, 1'b0, 32'h5,        32'h5,    1'b1, 1'b1, 32'h100};
    vecs[1]  = '{5'b01100, 32'h180, 32'h40, 1'b1, 32'hFFFFFFFF, 32'h0,    1'b1, 1'b0, 32'h0};
    vecs[2]  = '{5'b01100, 32'h200, 32'h48, 1'b1, 32'h0,        32'h0,    1'b0, 1'b1, 32'h48};
    vecs[3]  = '{5'b01001, 32'h210, 32'h4c, 1'b1, 32'h1,        32'h2,    1'b1, 1'b0, 32'h0};
    vecs[4]  = '{5'b01010, 32'h220, 32'h50, 1'b1, 32'h0,        32'h9,    1'b1, 1'b0, 32'h0};
    vecs[5]  = '{5'b01011, 32'h300, 32'h54, 1'b1, 32'h0,        32'h0,    1'b0, 1'b1, 32'h54};
    vecs[6]  = '{5'b01101, 32'h310, 32'h58, 1'b0, 32'h80000000, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[7]  = '{5'b01110, 32'h320, 32'h5c, 1'b1, 32'h0,        32'h0,    1'b0, 1'b1, 32'h5c};
    vecs[8]  = '{5'b10000, 32'h330, 32'h60, 1'b0, 32'h7,        32'h7,    1'b0, 1'b0, 32'h0};
    vecs[9]  = '{5'b00000, 32'h340, 32'h64, 1'b1, 32'h7,        32'h7,    1'b0, 1'b0, 32'h0};
    vecs[10] = '{5'b01011, 32'h350, 32'h68, 1'b1, 32'h7FFFFFFF, 32'h0,    1'b1, 1'b0, 32'h0};
    vecs[11] = '{5'b01001, 32'h360, 32'h6c, 1'b0, 32'h3,        32'h3,    1'b0, 1'b0, 32'h0};

    // Reset held with live ID inputs.
    rst = 1'b0;
    bif.stall = 1'b0;
    bif.flush_in = 1'b0;
    set_id(5'b01000, 32'h100, 32'h44, 1'b0);
    bif.rs_val = 32'h5;
    bif.rt_val = 32'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst type",   32'(bif.ex_branchType),   32'h0);
    chk("rst permit", 32'(bif.ex_branchPermit), 32'h0);
    chk("rst misp",   32'(bif.ex_mispredict),   32'h0);
    chk("rst redir",  bif.ex_redirectPc,        32'h0);
    chk_counters("rst");
    set_id(5'b00000, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;

    // Table-driven single branches.
    foreach (vecs[i]) begin
      @(negedge clk);
      set_id(vecs[i].btype, vecs[i].dst, vecs[i].pc4, vecs[i].pred);
      bif.rs_val = vecs[i].rs;
      bif.rt_val = vecs[i].rt;
      @(posedge clk); #1;
      set_id(5'b00000, 32'h0, 32'h0, 1'b0);
      #1;
      chk($sformatf("v%0d type", i),   32'(bif.ex_branchType),   32'(vecs[i].btype));
      chk($sformatf("v%0d permit", i), 32'(bif.ex_branchPermit), 32'(vecs[i].exp_permit));
      chk($sformatf("v%0d misp", i),   32'(bif.ex_mispredict),   32'(vecs[i].exp_misp));
      chk($sformatf("v%0d redir", i),  bif.ex_redirectPc,        vecs[i].exp_redir);
      if (vecs[i].btype[4:3] == 2'b01) raw_bc++;
      if (vecs[i].exp_misp) raw_mc++;
      @(posedge clk); #1;
      chk($sformatf("v%0d next type", i), 32'(bif.ex_branchType), 32'h0);
      chk_counters($sformatf("v%0d", i));
    end

    // Stalled BNE that mispredicts; flush during stall is ignored.
    @(negedge clk);
    set_id(5'b01001, 32'h400, 32'h70, 1'b0);
    bif.rs_val = 32'h1;
    bif.rt_val = 32'h2;
    @(posedge clk); #1;
    set_id(5'b00000, 32'h0, 32'h0, 1'b0);
    bif.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      bif.flush_in = (s == 1);
      #1;
      chk($sformatf("stall%0d type", s),   32'(bif.ex_branchType),   32'h09);
      chk($sformatf("stall%0d permit", s), 32'(bif.ex_branchPermit), 32'h1);
      chk($sformatf("stall%0d misp", s),   32'(bif.ex_mispredict),   32'h0);
      chk($sformatf("stall%0d redir", s),  bif.ex_redirectPc,        32'h0);
      @(posedge clk); #1;
      chk_counters($sformatf("stall%0d", s));
    end
    bif.stall = 1'b0;
    bif.flush_in = 1'b0;
    #1;
    chk("release type",  32'(bif.ex_branchType), 32'h09);
    chk("release misp",  32'(bif.ex_mispredict), 32'h1);
    chk("release redir", bif.ex_redirectPc,      32'h400);
    raw_bc++;
    raw_mc++;
    @(posedge clk); #1;
    chk("release next type", 32'(bif.ex_branchType), 32'h0);
    chk_counters("release");

    // Back-to-back, first mispredicts: second is killed.
    @(negedge clk);
    set_id(5'b01000, 32'h500, 32'h74, 1'b0);
    bif.rs_val = 32'h9;
    bif.rt_val = 32'h9;
    @(posedge clk); #1;
    set_id(5'b01001, 32'h600, 32'h78, 1'b1);
    #1;
    chk("b2b_m misp",  32'(bif.ex_mispredict), 32'h1);
    chk("b2b_m redir", bif.ex_redirectPc,      32'h500);
    raw_bc++;
    raw_mc++;
    @(posedge clk); #1;
    set_id(5'b00000, 32'h0, 32'h0, 1'b0);
    chk("b2b_m killed type", 32'(bif.ex_branchType), 32'h0);
    chk_counters("b2b_m");

    // Back-to-back, both predicted correctly: both resolve.
    @(negedge clk);
    set_id(5'b01000, 32'h700, 32'h7c, 1'b1);
    @(posedge clk); #1;
    set_id(5'b01001, 32'h800, 32'h80, 1'b1);
    #1;
    chk("b2b_ok1 permit", 32'(bif.ex_branchPermit), 32'h1);
    chk("b2b_ok1 misp",   32'(bif.ex_mispredict),   32'h0);
    raw_bc++;
    @(posedge clk); #1;
    set_id(5'b00000, 32'h0, 32'h0, 1'b0);
    bif.rs_val = 32'h1;
    bif.rt_val = 32'h2;
    #1;
    chk("b2b_ok2 type",   32'(bif.ex_branchType),   32'h09);
    chk("b2b_ok2 permit", 32'(bif.ex_branchPermit), 32'h1);
    chk("b2b_ok2 misp",   32'(bif.ex_mispredict),   32'h0);
    raw_bc++;
    @(posedge clk); #1;
    chk_counters("b2b_ok");

    // Drive mispredicts until the 4-bit instance is well past saturation.
    while (raw_mc < 18) begin
      @(negedge clk);
      set_id(5'b01000, 32'h900, 32'h84, 1'b0);
      bif.rs_val = 32'h4;
      bif.rt_val = 32'h4;
      @(posedge clk); #1;
      set_id(5'b00000, 32'h0, 32'h0, 1'b0);
      raw_bc++;
      raw_mc++;
      @(posedge clk); #1;
    end
    chk("sat misp pulse ok", 32'(bif.ex_mispredict), 32'h0);
    chk_counters("sat");

    // Reset asserted in a mispredict cycle: no increment survives.
    @(negedge clk);
    set_id(5'b01000, 32'hA00, 32'h88, 1'b0);
    @(posedge clk); #1;
    set_id(5'b00000, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    raw_bc = 0;
    raw_mc = 0;
    chk("rst_misp type", 32'(bif.ex_branchType), 32'h0);
    chk_counters("rst_misp");
    rst = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
